l0_xmem_loader: RTL and testbench

Read sequencer that streams activation/weight vectors from the input SRAM (xmem) into the L0 row buffer. It runs a programmed number of reads, with the L0 `o_full` signal as backpressure. It absorbs the one-cycle SRAM read latency with a one-entry skid register, so no vector is lost or duplicated. It sits directly upstream of L0 in the corelet datapath, which feeds the MAC array west edge.

---
 rtl/l0_xmem_loader.sv | 124 ++++++++++++
 tb/tb_l0_xmem_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l0_xmem_loader.sv
// Streams a programmed run of xmem words into the L0 row buffer, honouring
// L0 backpressure and absorbing the one-cycle SRAM read latency in a skid register.
module l0_xmem_loader #(
  parameter int unsigned row = 8,
  parameter int unsigned bw  = 4,
  parameter int unsigned aw  = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [aw-1:0]       base_addr,
  input  logic [aw:0]         num_vec,
  output logic                xmem_cen,
  output logic [aw-1:0]       xmem_a,
  input  logic [row*bw-1:0]   xmem_q,
  output logic [row*bw-1:0]   l0_in,
  output logic                l0_wr,
  input  logic                l0_full,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DW = row * bw;
  localparam int unsigned CW = aw + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [aw-1:0]   addr_q, addr_d;
  logic [CW-1:0]   rem_rd_q, rem_rd_d;
  logic [CW-1:0]   rem_wr_q, rem_wr_d;
  logic            rd_pend_q, rd_pend_d;
  logic            hold_v_q, hold_v_d;
  logic [DW-1:0]   skid_q, skid_d;
  logic            done_q, done_d;
  logic            issue;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_rd_q  <= '0;
      rem_wr_q  <= '0;
      rd_pend_q <= 1'b0;
      hold_v_q  <= 1'b0;
      skid_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_rd_q  <= rem_rd_d;
      rem_wr_q  <= rem_wr_d;
      rd_pend_q <= rd_pend_d;
      hold_v_q  <= hold_v_d;
      skid_q    <= skid_d;
      done_q    <= done_d;
    end
  end

  // A returning word bypasses the skid only when nothing is held and L0 has room
  assign l0_wr    = (hold_v_q || rd_pend_q) && !l0_full;
  assign l0_in    = hold_v_q ? skid_q : (rd_pend_q ? xmem_q : '0);
  assign xmem_cen = !issue;
  assign xmem_a   = addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  // Next-state, read issue and counter updates
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_rd_d  = rem_rd_q;
    rem_wr_d  = rem_wr_q;
    rd_pend_d = 1'b0;
    hold_v_d  = hold_v_q;
    skid_d    = skid_q;
    done_d    = 1'b0;

    issue = (state_q == RUN) && (rem_rd_q != '0) && !l0_full && !hold_v_q
            && !(rd_pend_q && l0_full);

    if (issue) begin
      addr_d    = aw'(addr_q + aw'(1));
      rem_rd_d  = CW'(rem_rd_q - CW'(1));
      rd_pend_d = 1'b1;
    end

    if (hold_v_q && !l0_full) begin
      hold_v_d = 1'b0;
    end else if (rd_pend_q && !hold_v_q && l0_full) begin
      hold_v_d = 1'b1;
      skid_d   = xmem_q;
    end

    if (l0_wr) begin
      rem_wr_d = CW'(rem_wr_q - CW'(1));
      if (rem_wr_q == CW'(1)) done_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            addr_d   = base_addr;
            rem_rd_d = num_vec;
            rem_wr_d = num_vec;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && (rem_rd_q == CW'(1))) state_d = DRAIN;
      end
      DRAIN: begin
        if (rem_wr_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l0_xmem_loader.sv
// Scoreboard bench for l0_xmem_loader: a memory model feeds xmem_q, expected
// addresses/data are queued at start and checked as the DUT reads and writes.
module tb_l0_xmem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] num_vec = '0;
  logic        xmem_cen;
  logic [10:0] xmem_a;
  logic [31:0] xmem_q = '0;
  logic [31:0] l0_in;
  logic        l0_wr;
  logic        l0_full = 1'b0;
  logic        busy;
  logic        done;

  // Narrow-address instance for the wrap scenario
  logic        start4 = 1'b0;
  logic [3:0]  base4 = '0;
  logic [4:0]  num4 = '0;
  logic        cen4;
  logic [3:0]  a4;
  logic [31:0] q4 = '0;
  logic [31:0] in4;
  logic        wr4;
  logic        full4 = 1'b0;
  logic        busy4;
  logic        done4;

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_a[$];
  logic [31:0] exp_d[$];

  l0_xmem_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .xmem_cen(xmem_cen), .xmem_a(xmem_a), .xmem_q(xmem_q), .l0_in(l0_in), .l0_wr(l0_wr),
    .l0_full(l0_full), .busy(busy), .done(done)
  );

  l0_xmem_loader #(.row(8), .bw(4), .aw(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .base_addr(base4), .num_vec(num4),
    .xmem_cen(cen4), .xmem_a(a4), .xmem_q(q4), .l0_in(in4), .l0_wr(wr4),
    .l0_full(full4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return {a[7:0], a[7:0], a[7:0], a[7:0]} ^ {21'd0, a};
  endfunction

  // SRAM models: data appears the cycle after a read
  always @(posedge clk) begin
    if (!xmem_cen) xmem_q <= mem_word(xmem_a);
    if (!cen4) q4 <= mem_word({7'd0, a4});
  end

  task automatic push_exp(input logic [10:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [10:0] a;
      a = base + 11'(i);
      exp_a.push_back(a);
      exp_d.push_back(mem_word(a));
    end
  endtask

  // Scoreboard monitor on the main instance
  always @(negedge clk) begin
    if (!xmem_cen) begin
      n_vec++;
      if (exp_a.size() == 0) begin
        n_err++;
        $display("FAIL mon_addr: unexpected read of %h", xmem_a);
      end else begin
        logic [10:0] ea;
        ea = exp_a.pop_front();
        if (xmem_a !== ea) begin
          n_err++;
          $display("FAIL mon_addr: got %h want %h", xmem_a, ea);
        end
      end
    end
    if (l0_wr) begin
      n_vec++;
      if (exp_d.size() == 0) begin
        n_err++;
        $display("FAIL mon_data: unexpected write of %h", l0_in);
      end else begin
        logic [31:0] ed;
        ed = exp_d.pop_front();
        if (l0_in !== ed) begin
          n_err++;
          $display("FAIL mon_data: got %h want %h", l0_in, ed);
        end
      end
    end
  end

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 3) reset = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({xmem_cen, l0_wr, busy, done} !== 4'b1000 || xmem_a !== 11'd0 || l0_in !== 32'd0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: cen/wr/busy/done=%b a=%h in=%h want 1000 0 0",
                 c, {xmem_cen, l0_wr, busy, done}, xmem_a, l0_in);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream();
    int first_rd = -1, last_rd = -1, nrd = 0, first_wr = -1, last_wr = -1, nwr = 0;
    int done_c = -1, ndone = 0, busy_fall = -1;
    push_exp(11'h010, 8);
    for (int c = 0; c < 14; c++) begin
      start = (c == 0); base_addr = 11'h010; num_vec = 12'd8;
      @(negedge clk);
      if (!xmem_cen) begin if (first_rd < 0) first_rd = c; last_rd = c; nrd++; end
      if (l0_wr) begin if (first_wr < 0) first_wr = c; last_wr = c; nwr++; end
      if (done) begin done_c = c; ndone++; end
      if (c > 1 && !busy && busy_fall < 0) busy_fall = c;
      @(posedge clk); #1;
    end
    n_vec++; if (first_rd !== 1) begin n_err++; $display("FAIL stream_first_rd: got %0d want 1", first_rd); end
    n_vec++; if (last_rd !== 8) begin n_err++; $display("FAIL stream_last_rd: got %0d want 8", last_rd); end
    n_vec++; if (nrd !== 8) begin n_err++; $display("FAIL stream_nrd: got %0d want 8", nrd); end
    n_vec++; if (first_wr !== 2) begin n_err++; $display("FAIL stream_first_wr: got %0d want 2", first_wr); end
    n_vec++; if (last_wr !== 9) begin n_err++; $display("FAIL stream_last_wr: got %0d want 9", last_wr); end
    n_vec++; if (nwr !== 8) begin n_err++; $display("FAIL stream_nwr: got %0d want 8", nwr); end
    n_vec++; if (done_c !== 10 || ndone !== 1) begin n_err++; $display("FAIL stream_done: at %0d x%0d want 10 x1", done_c, ndone); end
    n_vec++; if (busy_fall !== 10) begin n_err++; $display("FAIL stream_busy_fall: got %0d want 10", busy_fall); end
  endtask

  task automatic test_backpressure();
    int rq[$];
    int wq[$];
    int exp_r[4] = '{1, 2, 8, 9};
    int exp_w[4] = '{2, 7, 9, 10};
    int done_c = -1, ndone = 0;
    push_exp(11'h100, 4);
    for (int c = 0; c < 14; c++) begin
      start = (c == 0); base_addr = 11'h100; num_vec = 12'd4;
      l0_full = (c >= 3 && c <= 6);
      @(negedge clk);
      if (!xmem_cen) rq.push_back(c);
      if (l0_wr) wq.push_back(c);
      if (done) begin done_c = c; ndone++; end
      @(posedge clk); #1;
    end
    l0_full = 1'b0;
    n_vec++;
    if (rq.size() !== 4 || wq.size() !== 4) begin
      n_err++; $display("FAIL bp_counts: reads %0d writes %0d want 4 4", rq.size(), wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (rq[i] !== exp_r[i] || wq[i] !== exp_w[i]) begin
          n_err++; $display("FAIL bp_cycle%0d: rd %0d wr %0d want %0d %0d", i, rq[i], wq[i], exp_r[i], exp_w[i]);
        end
      end
    end
    n_vec++; if (done_c !== 11 || ndone !== 1) begin n_err++; $display("FAIL bp_done: at %0d x%0d want 11 x1", done_c, ndone); end
  endtask

  task automatic test_zero_and_ignore();
    int nrd = 0, done_c = -1, ndone = 0, nbusy = 0;
    for (int c = 0; c < 4; c++) begin
      start = (c == 0); base_addr = 11'h055; num_vec = 12'd0;
      @(negedge clk);
      if (!xmem_cen) nrd++;
      if (busy) nbusy++;
      if (done) begin done_c = c; ndone++; end
      @(posedge clk); #1;
    end
    n_vec++; if (done_c !== 1 || ndone !== 1) begin n_err++; $display("FAIL zero_done: at %0d x%0d want 1 x1", done_c, ndone); end
    n_vec++; if (nrd !== 0 || nbusy !== 0) begin n_err++; $display("FAIL zero_idle: reads %0d busy %0d want 0 0", nrd, nbusy); end
    nrd = 0; done_c = -1; ndone = 0;
    push_exp(11'h200, 5);
    for (int c = 0; c < 10; c++) begin
      start = (c == 0 || c == 2);
      base_addr = (c == 0) ? 11'h200 : 11'h300;
      num_vec   = (c == 0) ? 12'd5 : 12'd3;
      @(negedge clk);
      if (!xmem_cen) nrd++;
      if (done) begin done_c = c; ndone++; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_vec++; if (nrd !== 5) begin n_err++; $display("FAIL ignore_nrd: got %0d want 5", nrd); end
    n_vec++; if (done_c !== 7 || ndone !== 1) begin n_err++; $display("FAIL ignore_done: at %0d x%0d want 7 x1", done_c, ndone); end
    n_vec++; if (exp_a.size() !== 0 || exp_d.size() !== 0) begin n_err++; $display("FAIL ignore_left: %0d %0d want 0 0", exp_a.size(), exp_d.size()); end
  endtask

  task automatic test_wrap();
    logic [3:0]  aq[$];
    logic [31:0] dq[$];
    logic [3:0]  ea[3] = '{4'd15, 4'd0, 4'd1};
    int done_c = -1, done4_c = -1;
    push_exp(11'h7FF, 2);
    for (int c = 0; c < 8; c++) begin
      start = (c == 0); base_addr = 11'h7FF; num_vec = 12'd2;
      start4 = (c == 0); base4 = 4'd15; num4 = 5'd3;
      @(negedge clk);
      if (!cen4) aq.push_back(a4);
      if (wr4) dq.push_back(in4);
      if (done) done_c = c;
      if (done4) done4_c = c;
      @(posedge clk); #1;
    end
    start4 = 1'b0;
    n_vec++; if (done_c !== 4) begin n_err++; $display("FAIL wrap11_done: at %0d want 4", done_c); end
    n_vec++;
    if (aq.size() !== 3 || dq.size() !== 3) begin
      n_err++; $display("FAIL wrap4_counts: reads %0d writes %0d want 3 3", aq.size(), dq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (aq[i] !== ea[i] || dq[i] !== mem_word({7'd0, ea[i]})) begin
          n_err++; $display("FAIL wrap4_%0d: a=%h d=%h want %h %h", i, aq[i], dq[i], ea[i], mem_word({7'd0, ea[i]}));
        end
      end
    end
    n_vec++; if (done4_c !== 5 || busy4 !== 1'b0) begin n_err++; $display("FAIL wrap4_done: at %0d busy %b want 5 0", done4_c, busy4); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0, done_c = -1, nwr = 0;
    push_exp(11'h040, 8);
    for (int c = 0; c < 4; c++) begin
      start = (c == 0); base_addr = 11'h040; num_vec = 12'd8;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({xmem_cen, l0_wr, busy, done} !== 4'b1000 || xmem_a !== 11'd0 || l0_in !== 32'd0) begin
      n_err++; $display("FAIL reset_mid: cen/wr/busy/done=%b a=%h in=%h want 1000 0 0",
                        {xmem_cen, l0_wr, busy, done}, xmem_a, l0_in);
    end
    exp_a.delete(); exp_d.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
      @(posedge clk); #1;
    end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL reset_nodone: got %0d want 0", ndone); end
    push_exp(11'h7F0, 2);
    for (int c = 0; c < 7; c++) begin
      start = (c == 0); base_addr = 11'h7F0; num_vec = 12'd2;
      @(negedge clk);
      if (l0_wr) nwr++;
      if (done) done_c = c;
      @(posedge clk); #1;
    end
    n_vec++; if (done_c !== 4 || nwr !== 2) begin n_err++; $display("FAIL reset_fresh: done %0d writes %0d want 4 2", done_c, nwr); end
  endtask

  task automatic test_back_to_back();
    int nwr = 0, last_wr = -1, done_c = -1, ndone = 0, c = 0;
    push_exp(11'h3F0, 20);
    while (c < 300 && ndone == 0) begin
      start = (c == 0); base_addr = 11'h3F0; num_vec = 12'd20;
      l0_full = (c > 0) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (l0_wr) begin nwr++; last_wr = c; end
      if (done) begin done_c = c; ndone++; end
      @(posedge clk); #1;
      c++;
    end
    l0_full = 1'b0;
    n_vec++; if (ndone !== 1) begin n_err++; $display("FAIL rand_done: none within %0d cycles", c); end
    n_vec++; if (nwr !== 20) begin n_err++; $display("FAIL rand_nwr: got %0d want 20", nwr); end
    n_vec++; if (done_c !== last_wr + 1) begin n_err++; $display("FAIL rand_done_cyc: got %0d want %0d", done_c, last_wr + 1); end
    n_vec++; if (exp_d.size() !== 0) begin n_err++; $display("FAIL rand_left: %0d words not written", exp_d.size()); end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_zero_and_ignore();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
